// File: rtl/fifo_frame_unpacker.sv
// Read-side consumer of the prefetch FIFO: hunts for the sync word, unpacks one
// length-prefixed frame at a time and checks its 8-bit additive checksum.
module fifo_frame_unpacker #(
  parameter logic [7:0]  SYNC0    = 8'h55,
  parameter logic [7:0]  SYNC1    = 8'hAA,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned ERRCNT_W = 16
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                fifo_rd_vld,
  input  logic [7:0]          fifo_rd_data,
  output logic                fifo_rd_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_sof,
  output logic                out_eof,
  output logic                frame_done,
  output logic                frame_ok,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int unsigned    TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam bit             TMR_EN   = (TIMEOUT != 0);

  typedef enum logic [2:0] {ST_HUNT, ST_SYNC, ST_LEN, ST_PAY, ST_CKSUM} state_e;

  state_e              state_q, state_d;
  logic                run_q, run_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                out_sof_q, out_sof_d;
  logic                out_eof_q, out_eof_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_ok_q, frame_ok_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          count_q, count_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                pop_req;
  logic                take;
  logic                stall;
  logic                err_inc;

  // State register; run_q keeps pops off for the first cycle after reset
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q      <= ST_HUNT;
      run_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_cnt_q    <= '0;
      len_q        <= '0;
      sum_q        <= '0;
      count_q      <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      err_cnt_q    <= err_cnt_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
    end
  end

  // Pop handshake, frame parser, output register and idle timeout
  always_comb begin
    pop_req      = (state_q == ST_PAY) ? (!out_valid_q || out_ready) : 1'b1;
    fifo_rd_en   = run_q && !rd_rst && pop_req;
    take         = fifo_rd_en && fifo_rd_vld;
    stall        = (state_q == ST_PAY) && out_valid_q && !out_ready;

    state_d      = state_q;
    run_d        = 1'b1;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sof_d    = out_sof_q;
    out_eof_d    = out_eof_q;
    frame_done_d = 1'b0;
    frame_ok_d   = 1'b0;
    err_cnt_d    = err_cnt_q;
    len_d        = len_q;
    sum_d        = sum_q;
    count_d      = count_q;
    timer_d      = timer_q;
    err_inc      = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
    end

    // Backpressure freezes the timer so a slow sink never aborts a frame
    if (take) begin
      timer_d = '0;
    end else if (TMR_EN && (state_q != ST_HUNT) && !stall) begin
      if (timer_q == TMR_LAST) begin
        timer_d      = '0;
        frame_done_d = 1'b1;
        err_inc      = 1'b1;
        state_d      = ST_HUNT;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end

    if (take) begin
      case (state_q)
        ST_HUNT: begin
          if (fifo_rd_data == SYNC0) state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (fifo_rd_data == SYNC1)      state_d = ST_LEN;
          else if (fifo_rd_data != SYNC0) state_d = ST_HUNT;
        end
        ST_LEN: begin
          if (fifo_rd_data == 8'h00) begin
            frame_done_d = 1'b1;
            err_inc      = 1'b1;
            state_d      = ST_HUNT;
          end else begin
            len_d   = fifo_rd_data;
            sum_d   = fifo_rd_data;
            count_d = 8'h00;
            state_d = ST_PAY;
          end
        end
        ST_PAY: begin
          out_data_d  = fifo_rd_data;
          out_valid_d = 1'b1;
          out_sof_d   = (count_q == 8'h00);
          out_eof_d   = (count_q == len_q - 8'd1);
          sum_d       = sum_q + fifo_rd_data;
          count_d     = count_q + 8'd1;
          if (count_q == len_q - 8'd1) state_d = ST_CKSUM;
        end
        ST_CKSUM: begin
          frame_done_d = 1'b1;
          frame_ok_d   = (fifo_rd_data == sum_q);
          err_inc      = (fifo_rd_data != sum_q);
          state_d      = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fifo_frame_unpacker.sv
// Directed bench for fifo_frame_unpacker: a show-ahead FIFO model feeds bytes and
// accepted payload bytes plus frame_done pulses are logged per cycle.
module tb_fifo_frame_unpacker;

  localparam int unsigned TO = 4;
  localparam int unsigned EW = 2;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          fifo_rd_vld;
  logic [7:0]    fifo_rd_data;
  logic          fifo_rd_en;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_sof;
  logic          out_eof;
  logic          frame_done;
  logic          frame_ok;
  logic [EW-1:0] err_cnt;

  logic          stall_src;
  logic [7:0]    src_q[$];
  logic [7:0]    rx_d[$];
  logic          rx_sof[$];
  logic          rx_eof[$];
  int            rx_cyc[$];
  logic          ok_q[$];
  int            done_n;
  int            done_cyc;
  int            take_cyc;
  int            cyc;
  int            checks;
  int            errors;

  always #5 rd_clk = ~rd_clk;

  fifo_frame_unpacker #(
    .SYNC0   (8'h55),
    .SYNC1   (8'hAA),
    .TIMEOUT (TO),
    .ERRCNT_W(EW)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .fifo_rd_vld (fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .err_cnt     (err_cnt)
  );

  task automatic drive_src();
    fifo_rd_vld  = (src_q.size() != 0) && !stall_src;
    fifo_rd_data = (src_q.size() != 0) ? src_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    src_q.push_back(b);
    drive_src();
  endtask

  // One clock: observe on the falling edge, then update the FIFO head after the rise
  task automatic tick();
    logic [7:0] dummy;
    @(negedge rd_clk);
    cyc++;
    if (out_valid && out_ready) begin
      rx_d.push_back(out_data);
      rx_sof.push_back(out_sof);
      rx_eof.push_back(out_eof);
      rx_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_n++;
      done_cyc = cyc;
      ok_q.push_back(frame_ok);
    end
    if (fifo_rd_en && fifo_rd_vld) begin
      dummy    = src_q.pop_front();
      take_cyc = cyc;
    end
    @(posedge rd_clk);
    #1;
    drive_src();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_rx();
    rx_d.delete();
    rx_sof.delete();
    rx_eof.delete();
    rx_cyc.delete();
    ok_q.delete();
    done_n = 0;
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    src_q.delete();
    drive_src();
    tick();
    tick();
    rd_rst = 1'b0;
    tick();
    clear_rx();
  endtask

  task automatic test_reset();
    rd_rst = 1'b1;
    tick();
    checks++;
    if ({fifo_rd_en, out_valid, out_sof, out_eof, frame_done, frame_ok} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {fifo_rd_en, out_valid, out_sof, out_eof, frame_done, frame_ok});
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00", out_data);
    end
    checks++;
    if (err_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_err: got %0d expected 0", err_cnt);
    end
    rd_rst = 1'b0;
    run(2);
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL hunt_pop: got %b expected 1", fifo_rd_en);
    end
  endtask

  task automatic test_good_frame();
    do_reset();
    out_ready = 1'b1;
    push(8'h55); push(8'hAA); push(8'h03); push(8'h10); push(8'h20); push(8'h30); push(8'h63);
    run(14);
    checks++;
    if (rx_d.size() != 3 || {rx_d[0], rx_d[1], rx_d[2]} !== 24'h102030) begin
      errors++;
      $display("FAIL good_data: got %0d bytes %h %h %h expected 3 bytes 10 20 30",
               rx_d.size(), rx_d[0], rx_d[1], rx_d[2]);
    end
    checks++;
    if ({rx_sof[0], rx_sof[1], rx_sof[2], rx_eof[0], rx_eof[1], rx_eof[2]} !== 6'b100_001) begin
      errors++;
      $display("FAIL good_marks: got sof %b%b%b eof %b%b%b expected sof 100 eof 001",
               rx_sof[0], rx_sof[1], rx_sof[2], rx_eof[0], rx_eof[1], rx_eof[2]);
    end
    checks++;
    if (rx_cyc[1] != rx_cyc[0] + 1 || rx_cyc[2] != rx_cyc[0] + 2) begin
      errors++;
      $display("FAIL good_rate: got cycles %0d %0d %0d expected consecutive",
               rx_cyc[0], rx_cyc[1], rx_cyc[2]);
    end
    checks++;
    if (done_n != 1 || ok_q[0] !== 1'b1) begin
      errors++;
      $display("FAIL good_done: got %0d pulses ok=%b expected 1 pulse ok=1", done_n, ok_q[0]);
    end
    checks++;
    if (rx_cyc[2] > done_cyc || err_cnt !== 2'd0) begin
      errors++;
      $display("FAIL good_end: got eof cyc %0d done cyc %0d err %0d expected eof<=done err 0",
               rx_cyc[2], done_cyc, err_cnt);
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    out_ready = 1'b1;
    push(8'h55); push(8'hAA); push(8'h02); push(8'h01); push(8'h02); push(8'h00);
    run(12);
    checks++;
    if (rx_d.size() != 2 || {rx_d[0], rx_d[1]} !== 16'h0102) begin
      errors++;
      $display("FAIL bad_data: got %0d bytes %h %h expected 01 02", rx_d.size(), rx_d[0], rx_d[1]);
    end
    checks++;
    if (done_n != 1 || ok_q[0] !== 1'b0 || err_cnt !== 2'd1) begin
      errors++;
      $display("FAIL bad_status: got %0d pulses ok=%b err %0d expected 1 pulse ok=0 err 1",
               done_n, ok_q[0], err_cnt);
    end
  endtask

  task automatic test_resync();
    do_reset();
    out_ready = 1'b1;
    push(8'h12); push(8'h55); push(8'h55); push(8'hAA); push(8'h01); push(8'h7F); push(8'h80);
    push(8'h55); push(8'h00);
    push(8'h55); push(8'hAA); push(8'h01); push(8'h05); push(8'h06);
    run(22);
    checks++;
    if (rx_d.size() != 2 || {rx_d[0], rx_d[1]} !== 16'h7F05) begin
      errors++;
      $display("FAIL resync_data: got %0d bytes %h %h expected 7f 05", rx_d.size(), rx_d[0], rx_d[1]);
    end
    checks++;
    if ({rx_sof[0], rx_eof[0], rx_sof[1], rx_eof[1]} !== 4'b1111) begin
      errors++;
      $display("FAIL resync_marks: got %b%b%b%b expected 1111",
               rx_sof[0], rx_eof[0], rx_sof[1], rx_eof[1]);
    end
    checks++;
    if (done_n != 2 || {ok_q[0], ok_q[1]} !== 2'b11 || err_cnt !== 2'd0) begin
      errors++;
      $display("FAIL resync_status: got %0d pulses ok=%b%b err %0d expected 2 pulses ok=11 err 0",
               done_n, ok_q[0], ok_q[1], err_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    out_ready = 1'b0;
    push(8'h55); push(8'hAA); push(8'h03); push(8'h10); push(8'h20); push(8'h30); push(8'h63);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_wait: got out_valid %b expected 1 within 20 cycles", out_valid);
    end
    repeat (5) begin
      checks++;
      if ({fifo_rd_en, out_valid, out_sof, out_data} !== {1'b0, 1'b1, 1'b1, 8'h10}) begin
        errors++;
        $display("FAIL bp_hold: got en=%b vld=%b sof=%b data=%h expected en=0 vld=1 sof=1 data=10",
                 fifo_rd_en, out_valid, out_sof, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    run(12);
    checks++;
    if (rx_d.size() != 3 || {rx_d[0], rx_d[1], rx_d[2]} !== 24'h102030) begin
      errors++;
      $display("FAIL bp_data: got %0d bytes %h %h %h expected 10 20 30",
               rx_d.size(), rx_d[0], rx_d[1], rx_d[2]);
    end
    checks++;
    if (done_n != 1 || ok_q[0] !== 1'b1 || err_cnt !== 2'd0) begin
      errors++;
      $display("FAIL bp_status: got %0d pulses ok=%b err %0d expected 1 pulse ok=1 err 0",
               done_n, ok_q[0], err_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    out_ready = 1'b1;
    push(8'h55); push(8'hAA); push(8'h04); push(8'h01);
    run(14);
    checks++;
    if (done_n != 1 || ok_q[0] !== 1'b0 || err_cnt !== 2'd1) begin
      errors++;
      $display("FAIL to_status: got %0d pulses ok=%b err %0d expected 1 pulse ok=0 err 1",
               done_n, ok_q[0], err_cnt);
    end
    checks++;
    if (done_cyc - take_cyc != int'(TO) + 1) begin
      errors++;
      $display("FAIL to_delay: got %0d expected %0d", done_cyc - take_cyc, TO + 1);
    end
    checks++;
    if (rx_d.size() != 1 || {rx_d[0], rx_sof[0], rx_eof[0]} !== {8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL to_partial: got %0d bytes %h sof=%b eof=%b expected 01 sof=1 eof=0",
               rx_d.size(), rx_d[0], rx_sof[0], rx_eof[0]);
    end
    clear_rx();
    push(8'h55); push(8'hAA); push(8'h01); push(8'h05); push(8'h06);
    run(10);
    checks++;
    if (rx_d.size() != 1 || rx_d[0] !== 8'h05 || done_n != 1 || ok_q[0] !== 1'b1 || err_cnt !== 2'd1) begin
      errors++;
      $display("FAIL to_recover: got %0d bytes %h %0d pulses ok=%b err %0d expected 05 1 pulse ok=1 err 1",
               rx_d.size(), rx_d[0], done_n, ok_q[0], err_cnt);
    end
  endtask

  task automatic test_zero_len_sat();
    do_reset();
    out_ready = 1'b1;
    push(8'h55); push(8'hAA); push(8'h00);
    run(8);
    checks++;
    if (done_n != 1 || ok_q[0] !== 1'b0 || rx_d.size() != 0 || err_cnt !== 2'd1) begin
      errors++;
      $display("FAIL zlen: got %0d pulses ok=%b %0d bytes err %0d expected 1 pulse ok=0 0 bytes err 1",
               done_n, ok_q[0], rx_d.size(), err_cnt);
    end
    repeat (4) begin
      push(8'h55); push(8'hAA); push(8'h00);
    end
    run(20);
    checks++;
    if (done_n != 5 || err_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat: got %0d pulses err %0d expected 5 pulses err 3", done_n, err_cnt);
    end
  endtask

  task automatic test_reset_mid_pay();
    int n;
    do_reset();
    out_ready = 1'b0;
    push(8'h55); push(8'hAA); push(8'h00);
    push(8'h55); push(8'hAA); push(8'h04); push(8'h01); push(8'h02);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || err_cnt !== 2'd1) begin
      errors++;
      $display("FAIL rst_pre: got vld=%b err %0d expected vld=1 err 1", out_valid, err_cnt);
    end
    rd_rst = 1'b1;
    src_q.delete();
    drive_src();
    tick();
    checks++;
    if ({fifo_rd_en, out_valid, out_sof, out_eof, frame_done, frame_ok, out_data, err_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got en=%b vld=%b sof=%b eof=%b done=%b ok=%b data=%h err=%0d expected all 0",
               fifo_rd_en, out_valid, out_sof, out_eof, frame_done, frame_ok, out_data, err_cnt);
    end
    rd_rst = 1'b0;
    out_ready = 1'b1;
    run(8);
    checks++;
    if (done_n != 1 || err_cnt !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: got %0d pulses err %0d vld=%b expected 1 pulse err 0 vld=0",
               done_n, err_cnt, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    push(8'h55); push(8'hAA); push(8'h02); push(8'h11); push(8'h22); push(8'h35);
    push(8'h55); push(8'hAA); push(8'h01); push(8'h44); push(8'h45);
    run(18);
    checks++;
    if (rx_d.size() != 3 || {rx_d[0], rx_d[1], rx_d[2]} !== 24'h112244) begin
      errors++;
      $display("FAIL b2b_data: got %0d bytes %h %h %h expected 11 22 44",
               rx_d.size(), rx_d[0], rx_d[1], rx_d[2]);
    end
    checks++;
    if (rx_cyc[1] != rx_cyc[0] + 1 || rx_cyc[2] != rx_cyc[1] + 5) begin
      errors++;
      $display("FAIL b2b_rate: got cycles %0d %0d %0d expected gaps 1 and 5",
               rx_cyc[0], rx_cyc[1], rx_cyc[2]);
    end
    checks++;
    if (done_n != 2 || {ok_q[0], ok_q[1]} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_status: got %0d pulses ok=%b%b expected 2 pulses ok=11",
               done_n, ok_q[0], ok_q[1]);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    done_n       = 0;
    done_cyc     = 0;
    take_cyc     = 0;
    rd_rst       = 1'b1;
    out_ready    = 1'b1;
    stall_src    = 1'b0;
    fifo_rd_vld  = 1'b0;
    fifo_rd_data = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_resync();
    test_backpressure();
    test_timeout();
    test_zero_len_sat();
    test_reset_mid_pay();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
